dbuf_framebuf: RTL and testbench

//  Parametrised double-buffered LED-panel framebuffer: two internal RAM banks, one displayed (front),
//  one written by the update side (back). Bank swap is requested by the writer and committed only at a

---
 rtl/dbuf_framebuf_if.sv | 32 +++
 rtl/dbuf_framebuf.sv | 116 +++++++++++
 tb/tb_dbuf_framebuf.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dbuf_framebuf_if.sv
// Framebuffer bus: scanner display port, renderer update port and swap control/status.
// master = renderer/scanner side, slave = framebuffer.
interface dbuf_framebuf_if #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 6,
  parameter int CW       = 8
);
  logic [ROW_BITS-1:0]          disp_row;
  logic [COL_BITS-1:0]          disp_col;
  logic                         disp_re;
  logic [3*CW-1:0]              disp_rgb;
  logic                         frame_end;
  logic [ROW_BITS+COL_BITS-1:0] upd_addr;
  logic                         upd_we;
  logic [3*CW-1:0]              upd_data;
  logic [3*CW-1:0]              upd_q;
  logic                         swap_req;
  logic                         swap_pending;
  logic                         swap_done;
  logic                         clearing;
  logic                         front;

  modport master (
    output disp_row, disp_col, disp_re, frame_end, upd_addr, upd_we, upd_data, swap_req,
    input  disp_rgb, upd_q, swap_pending, swap_done, clearing, front
  );

  modport slave (
    input  disp_row, disp_col, disp_re, frame_end, upd_addr, upd_we, upd_data, swap_req,
    output disp_rgb, upd_q, swap_pending, swap_done, clearing, front
  );
endinterface

// File: rtl/dbuf_framebuf.sv
// Double-buffered LED framebuffer; swap commits only at frame_end, optional auto-clear of new back bank.
// Latency: display and update reads 1 cycle; swap_done 1 cycle after commit.
// Backpressure: none; display never stalls, update writes are dropped while clearing.
module dbuf_framebuf #(
  parameter int ROW_BITS      = 3,
  parameter int COL_BITS      = 6,
  parameter int CW            = 8,
  parameter int FOLD          = 1,
  parameter int CLEAR_ON_SWAP = 0
) (
  input logic             clk,
  input logic             reset,
  dbuf_framebuf_if.slave  b
);
  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = 3 * CW;

  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;

  state_t          state;
  logic            front_q;
  logic            pending_q;
  logic            done_q;
  logic            clearing_q;
  logic [AW-1:0]   clr_cnt;
  logic [DW-1:0]   disp_q;
  logic [DW-1:0]   upd_q;
  logic [DW-1:0]   bank0 [DEPTH];
  logic [DW-1:0]   bank1 [DEPTH];

  logic [AW-1:0]   disp_addr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_en;
  logic            commit;

  // Split panel: upper half of the columns maps to the lower half of the bank.
  generate
    if (FOLD != 0) begin : g_fold
      assign disp_addr = {~b.disp_col[COL_BITS-1], b.disp_row, b.disp_col[COL_BITS-2:0]};
    end else begin : g_linear
      assign disp_addr = {b.disp_row, b.disp_col};
    end
  endgenerate

  assign commit  = b.frame_end && (((state == IDLE) && b.swap_req) || (state == PENDING));
  assign wr_en   = !reset && (clearing_q || b.upd_we);
  assign wr_addr = clearing_q ? clr_cnt : b.upd_addr;
  assign wr_data = clearing_q ? '0 : b.upd_data;

  // Back bank is always ~front; registered front keeps commit-cycle accesses on the old banks.
  always_ff @(posedge clk) begin
    if (wr_en && front_q)  bank0[wr_addr] <= wr_data;
    if (wr_en && !front_q) bank1[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q <= '0;
      upd_q  <= '0;
    end else begin
      if (b.disp_re) disp_q <= front_q ? bank1[disp_addr] : bank0[disp_addr];
      upd_q <= clearing_q ? '0 : (front_q ? bank0[b.upd_addr] : bank1[b.upd_addr]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      front_q    <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      clearing_q <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      done_q <= commit;
      case (state)
        IDLE: begin
          if (b.swap_req && !b.frame_end) begin
            state     <= PENDING;
            pending_q <= 1'b1;
          end
        end
        PENDING: ;
        CLEAR: begin
          if (b.swap_req) pending_q <= 1'b1;
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            clearing_q <= 1'b0;
            state      <= (pending_q || b.swap_req) ? PENDING : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        front_q   <= ~front_q;
        pending_q <= 1'b0;
        if (CLEAR_ON_SWAP != 0) begin
          state      <= CLEAR;
          clearing_q <= 1'b1;
          clr_cnt    <= '0;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign b.disp_rgb     = disp_q;
  assign b.upd_q        = upd_q;
  assign b.swap_pending = pending_q;
  assign b.swap_done    = done_q;
  assign b.clearing     = clearing_q;
  assign b.front        = front_q;
endmodule

// File: tb/tb_dbuf_framebuf.sv
// Directed bench: dut0 without auto-clear, dut1 with auto-clear (both folded, 3x6 address bits).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_dbuf_framebuf;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  dbuf_framebuf_if bus0 ();
  dbuf_framebuf_if bus1 ();

  dbuf_framebuf #(.CLEAR_ON_SWAP(0)) dut0 (.clk(clk), .reset(rst0), .b(bus0));
  dbuf_framebuf #(.CLEAR_ON_SWAP(1)) dut1 (.clk(clk), .reset(rst1), .b(bus1));

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [23:0] data;
    logic        chk;
    logic [23:0] exp_q;
  } vec_t;

  vec_t vt [10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle0();
    bus0.disp_row = '0; bus0.disp_col = '0; bus0.disp_re = 1'b0; bus0.frame_end = 1'b0;
    bus0.upd_addr = '0; bus0.upd_we = 1'b0; bus0.upd_data = '0; bus0.swap_req = 1'b0;
  endtask

  task automatic idle1();
    bus1.disp_row = '0; bus1.disp_col = '0; bus1.disp_re = 1'b0; bus1.frame_end = 1'b0;
    bus1.upd_addr = '0; bus1.upd_we = 1'b0; bus1.upd_data = '0; bus1.swap_req = 1'b0;
  endtask

  function automatic logic [23:0] pat(input int a);
    return 24'(a * 37 + 'h010203);
  endfunction

  // Folded display address: {~col[5], row, col[4:0]}
  function automatic int dmap(input int row, input int col);
    return ((((col >> 5) & 1) ^ 1) << 8) | (row << 5) | (col & 31);
  endfunction

  initial begin
    int pend, dn, clr;
    int rows [4];
    int cols [4];

    vt[0] = '{1'b1, 9'd5,   24'h112233, 1'b0, 24'h000000};
    vt[1] = '{1'b0, 9'd5,   24'h000000, 1'b1, 24'h112233};
    vt[2] = '{1'b1, 9'd5,   24'hAABBCC, 1'b1, 24'h112233};
    vt[3] = '{1'b0, 9'd5,   24'h000000, 1'b1, 24'hAABBCC};
    vt[4] = '{1'b1, 9'd6,   24'h000001, 1'b0, 24'h000000};
    vt[5] = '{1'b0, 9'd6,   24'h000000, 1'b1, 24'h000001};
    vt[6] = '{1'b0, 9'd5,   24'h000000, 1'b1, 24'hAABBCC};
    vt[7] = '{1'b1, 9'd511, 24'hFFFFFF, 1'b0, 24'h000000};
    vt[8] = '{1'b0, 9'd511, 24'h000000, 1'b1, 24'hFFFFFF};
    vt[9] = '{1'b0, 9'd6,   24'h000000, 1'b1, 24'h000001};
    rows = '{0, 3, 7, 5};
    cols = '{0, 35, 63, 10};

    rst0 = 1'b1; rst1 = 1'b1;
    idle0(); idle1();
    @(negedge clk);
    tick(); tick();
    check("rst_front",   {31'd0, bus0.front},        32'd0);
    check("rst_pending", {31'd0, bus0.swap_pending}, 32'd0);
    check("rst_done",    {31'd0, bus0.swap_done},    32'd0);
    check("rst_clear",   {31'd0, bus1.clearing},     32'd0);
    check("rst_rgb",     bus0.disp_rgb,              32'd0);
    check("rst_q",       bus0.upd_q,                 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Update port read/write, read-before-write; display untouched
    for (int i = 0; i < 10; i++) begin
      bus0.upd_we = vt[i].we; bus0.upd_addr = vt[i].addr; bus0.upd_data = vt[i].data;
      tick();
      if (vt[i].chk) check("upd_q_vec", bus0.upd_q, vt[i].exp_q);
      check("disp_idle", bus0.disp_rgb, 32'd0);
    end
    idle0();

    // Fill back bank, swap with frame_end 10 cycles after the request
    for (int a = 0; a < 512; a++) begin
      bus0.upd_we = 1'b1; bus0.upd_addr = 9'(a); bus0.upd_data = pat(a);
      tick();
    end
    idle0();
    pend = 0; dn = 0;
    for (int k = 0; k < 16; k++) begin
      bus0.swap_req  = (k == 0 || k == 5);
      bus0.frame_end = (k == 10);
      tick();
      if (bus0.swap_pending) pend++;
      if (bus0.swap_done) dn++;
    end
    idle0();
    check("pending_cycles", pend, 10);
    check("done_pulses",    dn,   1);
    check("front_after",    {31'd0, bus0.front}, 32'd1);
    bus0.frame_end = 1'b1;
    tick();
    bus0.frame_end = 1'b0;
    check("no_queued_swap", {31'd0, bus0.front}, 32'd1);
    check("no_pending",     {31'd0, bus0.swap_pending}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus0.disp_re = 1'b1; bus0.disp_row = 3'(rows[i]); bus0.disp_col = 6'(cols[i]);
      tick();
      check("disp_swap", bus0.disp_rgb, pat(dmap(rows[i], cols[i])));
    end
    bus0.disp_re = 1'b0; bus0.disp_row = 3'd1; bus0.disp_col = 6'd1;
    tick();
    check("disp_hold", bus0.disp_rgb, pat(dmap(5, 10)));
    idle0();

    // Fold corner and same-cycle swap request + frame_end
    bus0.upd_we = 1'b1; bus0.upd_addr = 9'd0; bus0.upd_data = 24'hC0FFEE;
    tick();
    idle0();
    bus0.swap_req = 1'b1; bus0.frame_end = 1'b1;
    tick();
    idle0();
    check("imm_pending", {31'd0, bus0.swap_pending}, 32'd0);
    check("imm_done",    {31'd0, bus0.swap_done},    32'd1);
    check("imm_front",   {31'd0, bus0.front},        32'd0);
    bus0.disp_re = 1'b1; bus0.disp_row = 3'd0; bus0.disp_col = 6'd32;
    tick();
    check("imm_done_drop", {31'd0, bus0.swap_done}, 32'd0);
    check("fold_r0c32",    bus0.disp_rgb, 24'hC0FFEE);
    idle0();

    // Auto-clear: preload back bank then swap
    bus1.upd_we = 1'b1;
    bus1.upd_addr = 9'd99;  bus1.upd_data = 24'h999999; tick();
    bus1.upd_addr = 9'd100; bus1.upd_data = 24'h100100; tick();
    bus1.upd_addr = 9'd101; bus1.upd_data = 24'h101101; tick();
    idle1();
    bus1.swap_req = 1'b1; bus1.frame_end = 1'b1;
    tick();
    idle1();
    check("clr_front", {31'd0, bus1.front}, 32'd1);
    clr = bus1.clearing ? 1 : 0;
    for (int k = 1; k <= 520; k++) begin
      idle1();
      bus1.swap_req  = (k == 200);
      bus1.frame_end = (k == 250);
      if (k >= 390 && k < 400) begin
        bus1.upd_we = 1'b1; bus1.upd_addr = 9'd300; bus1.upd_data = 24'h123456;
      end
      if (k == 100) begin
        bus1.disp_re = 1'b1; bus1.disp_row = 3'd3; bus1.disp_col = 6'd35;
      end
      tick();
      if (bus1.clearing) clr++;
      if (k == 100) check("clr_disp_live", bus1.disp_rgb, 24'h999999);
      if (k == 260) check("clr_latched_req", {31'd0, bus1.swap_pending}, 32'd1);
      if (k == 260) check("clr_no_commit",   {31'd0, bus1.front},        32'd1);
      if (k == 395) check("clr_q_zero",      bus1.upd_q,                 32'd0);
    end
    idle1();
    check("clr_cycles",      clr, 512);
    check("post_clr_pend",   {31'd0, bus1.swap_pending}, 32'd1);
    for (int a = 0; a < 512; a++) begin
      bus1.upd_addr = 9'(a);
      tick();
      check("cleared_word", bus1.upd_q, 32'd0);
    end
    idle1();
    bus1.frame_end = 1'b1;
    tick();
    idle1();
    check("clr2_front",    {31'd0, bus1.front},        32'd0);
    check("clr2_pend",     {31'd0, bus1.swap_pending}, 32'd0);
    check("clr2_clearing", {31'd0, bus1.clearing},     32'd1);

    // Reset when the clear counter reaches 100
    for (int k = 0; k < 100; k++) tick();
    rst1 = 1'b1;
    tick();
    check("mid_rst_clearing", {31'd0, bus1.clearing},     32'd0);
    check("mid_rst_front",    {31'd0, bus1.front},        32'd0);
    check("mid_rst_pend",     {31'd0, bus1.swap_pending}, 32'd0);
    rst1 = 1'b0;
    bus1.upd_addr = 9'd0;   tick(); check("part_clr_0",   bus1.upd_q, 32'd0);
    bus1.upd_addr = 9'd50;  tick(); check("part_clr_50",  bus1.upd_q, 32'd0);
    bus1.upd_addr = 9'd99;  tick(); check("part_clr_99",  bus1.upd_q, 32'd0);
    bus1.upd_addr = 9'd100; tick(); check("part_keep_100", bus1.upd_q, 24'h100100);
    bus1.upd_addr = 9'd101; tick(); check("part_keep_101", bus1.upd_q, 24'h101101);
    tick();
    check("idle_after_rst", {31'd0, bus1.clearing}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
